ava_indexed_mode: RTL and testbench

//  Parametrised successor of the 8bpp direct renderer: turns a linear pixel coordinate into a 24-bit colour.

---
 rtl/ava_pkg.sv | 35 +++
 rtl/ava_pixel_unpack.sv | 24 ++
 rtl/ava_indexed_mode.sv | 81 ++++++++
 tb/tb_ava_indexed_mode.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ava_pkg.sv
// Shared types and helpers for the indexed-colour renderer: bpp modes, s1 stage record,
// and the mode-dependent word shift / sub-index mask. No logic, no latency, no backpressure.
package ava_pkg;

    localparam int VRAM_ADDR_WIDTH = 12;
    localparam int PRAM_ADDR_WIDTH = 8;
    localparam int WORD_W          = 32;
    localparam int SUB_W           = 5;
    localparam int IDX_W           = 8;

    typedef enum logic [1:0] {
        BPP1 = 2'd0,
        BPP2 = 2'd1,
        BPP4 = 2'd2,
        BPP8 = 2'd3
    } ava_bpp_e;

    // Palette base lives beside this record in the top because its width is a module parameter.
    typedef struct packed {
        logic             valid;
        logic             blank;
        ava_bpp_e         mode;
        logic [SUB_W-1:0] sub;
    } ava_s1_t;

    // log2(pixels per 32-bit word)
    function automatic logic [2:0] word_shift(input ava_bpp_e m);
        return 3'd5 - {1'b0, m};
    endfunction

    function automatic logic [SUB_W-1:0] sub_mask(input ava_bpp_e m);
        return 5'h1F >> m;
    endfunction

endpackage

// File: rtl/ava_pixel_unpack.sv
// Extracts one packed pixel index from a 32-bit VRAM word; purely combinational, zero latency.
// No flow control: output follows inputs.
module ava_pixel_unpack
    import ava_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [SUB_W-1:0]  sub,
    input  logic [1:0]        mode,
    output logic [IDX_W-1:0]  idx
);

    logic [SUB_W-1:0] bit_off;
    logic [IDX_W-1:0] shifted;
    logic [IDX_W-1:0] mask;

    // sub is always below 32>>mode, so sub*bpp fits in five bits
    always_comb begin
        bit_off = sub << mode;
        shifted = IDX_W'(word >> bit_off);
        mask    = 8'hFF >> (4'd8 - (4'd1 << mode));
        idx     = shifted & mask;
    end

endmodule

// File: rtl/ava_indexed_mode.sv
// Linear coordinate -> VRAM word -> palette index -> 24-bit colour, 3 en-cycles latency, 1 pixel/cycle.
// en=0 freezes every stage and both RAM read ports, so stalls lose and duplicate nothing.
module ava_indexed_mode
    import ava_pkg::*;
#(
    parameter int               VRAM_AW     = VRAM_ADDR_WIDTH,
    parameter int               PRAM_AW     = PRAM_ADDR_WIDTH,
    parameter int               COLOR_W     = 24,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    input  logic [VRAM_AW-1:0] linear_coords,
    input  logic               in_blank,
    input  logic [1:0]         mode,
    input  logic [PRAM_AW-1:0] palette_base,
    output logic [VRAM_AW-1:0] vram_a,
    output logic               vram_re,
    input  logic [WORD_W-1:0]  vram_d,
    output logic [PRAM_AW-1:0] palette_a,
    output logic               palette_re,
    input  logic [WORD_W-1:0]  palette_d,
    output logic               out_valid,
    output logic [COLOR_W-1:0] pixel_out
);

    ava_bpp_e         mode_e;
    logic [SUB_W-1:0] sub_in;
    ava_s1_t          s1;
    logic [PRAM_AW-1:0] s1_base;
    logic             s2_valid;
    logic             s2_blank;
    logic [IDX_W-1:0] idx;
    logic             unused_pal_hi;

    assign mode_e = ava_bpp_e'(mode);

    // Both RAM ports advance exactly when the pipeline does; held RAM outputs make stalls lossless.
    assign vram_re    = en;
    assign palette_re = en;

    assign vram_a = linear_coords >> word_shift(mode_e);
    assign sub_in = linear_coords[SUB_W-1:0] & sub_mask(mode_e);

    ava_pixel_unpack u_unpack (
        .word (vram_d),
        .sub  (s1.sub),
        .mode (s1.mode),
        .idx  (idx)
    );

    assign palette_a     = s1_base + PRAM_AW'(idx);
    assign unused_pal_hi = ^palette_d[WORD_W-1:24];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s1_base   <= '0;
            s2_valid  <= 1'b0;
            s2_blank  <= 1'b0;
            out_valid <= 1'b0;
            pixel_out <= '0;
        end else if (en) begin
            s1.valid  <= in_valid;
            s1.blank  <= in_blank;
            s1.mode   <= mode_e;
            s1.sub    <= sub_in;
            s1_base   <= palette_base;
            s2_valid  <= s1.valid;
            s2_blank  <= s1.blank;
            out_valid <= s2_valid;
            // bubbles leave the last colour on the bus
            if (s2_valid) begin
                pixel_out <= s2_blank ? BLANK_COLOR : COLOR_W'(palette_d[23:0]);
            end
        end
    end

endmodule

// File: tb/tb_ava_indexed_mode.sv
// Randomised and directed bench for ava_indexed_mode with behavioural VRAM/palette RAMs
// and an arithmetic reference model; also exercises ava_pixel_unpack standalone.
module tb_ava_indexed_mode;
    import ava_pkg::*;

    localparam int VAW = VRAM_ADDR_WIDTH;
    localparam int PAW = PRAM_ADDR_WIDTH;
    localparam logic [23:0] BLANK = 24'h000000;

    logic           clk = 1'b0;
    logic           reset, en, in_valid, in_blank;
    logic [VAW-1:0] linear_coords;
    logic [1:0]     mode;
    logic [PAW-1:0] palette_base;
    logic [VAW-1:0] vram_a;
    logic           vram_re, palette_re, out_valid;
    logic [31:0]    vram_d = '0;
    logic [31:0]    palette_d = '0;
    logic [PAW-1:0] palette_a;
    logic [23:0]    pixel_out;

    logic [31:0] u_word;
    logic [4:0]  u_sub;
    logic [1:0]  u_mode;
    logic [7:0]  u_idx;

    logic [31:0] vram_mem [0:(1<<VAW)-1];
    logic [31:0] pal_mem  [0:(1<<PAW)-1];

    typedef struct {
        logic           valid;
        logic [PAW-1:0] paddr;
        logic [23:0]    colour;
    } exp_t;

    exp_t        hist[$];
    logic [23:0] exp_pix;
    logic [PAW-1:0] pa_log[$];
    logic [23:0] out_log[$];
    logic [23:0] want[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_re)    vram_d    <= vram_mem[vram_a];
        if (palette_re) palette_d <= pal_mem[palette_a];
    end

    ava_indexed_mode #(
        .VRAM_AW(VAW), .PRAM_AW(PAW), .COLOR_W(24), .BLANK_COLOR(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .linear_coords(linear_coords), .in_blank(in_blank), .mode(mode),
        .palette_base(palette_base), .vram_a(vram_a), .vram_re(vram_re),
        .vram_d(vram_d), .palette_a(palette_a), .palette_re(palette_re),
        .palette_d(palette_d), .out_valid(out_valid), .pixel_out(pixel_out)
    );

    ava_pixel_unpack u_unpack (.word(u_word), .sub(u_sub), .mode(u_mode), .idx(u_idx));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // What the pixel at (coord, mode, base) must produce, straight from the packing rules.
    function automatic exp_t model(input logic v, input logic [VAW-1:0] c, input logic b,
                                   input logic [1:0] m, input logic [PAW-1:0] base);
        exp_t        e;
        int          bpp;
        int          ppw;
        int          pos;
        int          pidx;
        logic [31:0] w;
        bpp    = 1 << m;
        ppw    = 32 / bpp;
        w      = vram_mem[int'(c) / ppw];
        pos    = int'(c) % ppw;
        pidx   = int'((w >> (pos * bpp)) & 32'((1 << bpp) - 1));
        e.valid  = v;
        e.paddr  = PAW'((int'(base) + pidx) % (1 << PAW));
        e.colour = b ? BLANK : pal_mem[e.paddr][23:0];
        return e;
    endfunction

    function automatic exp_t empty_ent();
        exp_t e;
        e.valid = 1'b0; e.paddr = '0; e.colour = '0;
        return e;
    endfunction

    task automatic step(input logic v, input logic [VAW-1:0] c, input logic b, input logic [1:0] m,
                        input logic [PAW-1:0] base, input logic e, input logic r);
        exp_t ent;
        in_valid = v; linear_coords = c; in_blank = b; mode = m;
        palette_base = base; en = e; reset = r;
        ent = model(v, c, b, m, base);
        #1;
        if (e && v) check_val("vram_a", 32'(vram_a), 32'(int'(c) / (32 >> m)));
        check_val("vram_re", 32'(vram_re), 32'(e));
        @(posedge clk);
        @(negedge clk);
        if (r) begin
            hist = {};
            repeat (3) hist.push_back(empty_ent());
            exp_pix = '0;
        end else if (e) begin
            hist.push_back(ent);
            void'(hist.pop_front());
            if (hist[0].valid) exp_pix = hist[0].colour;
            if (out_valid) out_log.push_back(pixel_out);
            if (hist[2].valid) pa_log.push_back(palette_a);
        end
        check_val("out_valid", 32'(out_valid), 32'(hist[0].valid));
        check_val("pixel_out", 32'(pixel_out), 32'(exp_pix));
        if (hist[2].valid) check_val("palette_a", 32'(palette_a), 32'(hist[2].paddr));
    endtask

    task automatic bubbles(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 2'd3, '0, 1'b1, 1'b0);
    endtask

    task automatic clear_logs();
        pa_log = {}; out_log = {}; want = {};
    endtask

    task automatic check_outs(input string tag);
        check_val({tag, "_count"}, 32'(out_log.size()), 32'(want.size()));
        for (int k = 0; k < want.size(); k++)
            if (k < out_log.size()) check_val(tag, 32'(out_log[k]), 32'(want[k]));
    endtask

    initial begin
        logic [7:0]     t1_pa [4];
        logic [7:0]     t2_pa [3];
        logic [VAW-1:0] cc;
        logic [1:0]     mm;
        exp_t           ee;
        t1_pa = '{8'h11, 8'h22, 8'h33, 8'h44};
        t2_pa = '{8'h11, 8'h10, 8'h11};
        for (int i = 0; i < (1 << VAW); i++) vram_mem[i] = $urandom;
        for (int i = 0; i < (1 << PAW); i++) pal_mem[i]  = $urandom | 32'h1;
        repeat (3) hist.push_back(empty_ent());
        exp_pix = '0;

        // standalone unpacker
        for (int i = 0; i < 40; i++) begin
            int bpp;
            u_word = $urandom;
            u_mode = 2'($urandom_range(0, 3));
            bpp    = 1 << u_mode;
            u_sub  = 5'($urandom_range(0, (32 >> u_mode) - 1));
            #1;
            check_val("unpack_idx", 32'(u_idx),
                      (u_word >> (int'(u_sub) * bpp)) & 32'((1 << bpp) - 1));
        end

        step(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 2'd0, '0, 1'b1, 1'b1);

        // 8bpp, word 0 = 44332211
        vram_mem[0] = 32'h44332211;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, VAW'(i), 1'b0, 2'd3, '0, 1'b1, 1'b0);
            want.push_back(pal_mem[t1_pa[i]][23:0]);
        end
        bubbles(3);
        check_val("t1_pa_count", 32'(pa_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < pa_log.size()) check_val("t1_palette_a", 32'(pa_log[i]), 32'(t1_pa[i]));
        check_outs("t1_pixel");

        // 1bpp, word 0 = 8000_0001, base 0x10
        vram_mem[0] = 32'h8000_0001;
        clear_logs();
        step(1'b1, VAW'(0),  1'b0, 2'd0, 8'h10, 1'b1, 1'b0);
        step(1'b1, VAW'(1),  1'b0, 2'd0, 8'h10, 1'b1, 1'b0);
        step(1'b1, VAW'(31), 1'b0, 2'd0, 8'h10, 1'b1, 1'b0);
        step(1'b1, VAW'(32), 1'b0, 2'd0, 8'h10, 1'b1, 1'b0);
        bubbles(3);
        for (int i = 0; i < 3; i++)
            if (i < pa_log.size()) check_val("t2_palette_a", 32'(pa_log[i]), 32'(t2_pa[i]));
        in_valid = 1'b1; linear_coords = VAW'(32); mode = 2'd0; #1;
        check_val("t2_vram_a_32", 32'(vram_a), 32'd1);

        // 4bpp palette wrap: nibble F at coord 19 (word 2, position 3)
        vram_mem[2] = 32'h0000_F000;
        clear_logs();
        step(1'b1, VAW'(19), 1'b0, 2'd2, '1, 1'b1, 1'b0);
        bubbles(3);
        if (pa_log.size() > 0) check_val("t3_wrap", 32'(pa_log[0]), 32'd14);
        else check_val("t3_wrap_count", 32'(pa_log.size()), 32'd1);

        // 6 pixels with a 2-cycle stall after the third
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                step(1'b1, VAW'($urandom), 1'b0, 2'd1, 8'h3C, 1'b0, 1'b0);
                step(1'b1, VAW'($urandom), 1'b0, 2'd2, 8'h5A, 1'b0, 1'b0);
            end
            cc = VAW'($urandom); mm = 2'($urandom_range(0, 3));
            ee = model(1'b1, cc, 1'b0, mm, 8'h20);
            want.push_back(ee.colour);
            step(1'b1, cc, 1'b0, mm, 8'h20, 1'b1, 1'b0);
        end
        bubbles(3);
        check_outs("t4_stall");

        // blank on pixel 2 of 4
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            cc = VAW'($urandom);
            ee = model(1'b1, cc, 1'b0, 2'd3, 8'h00);
            want.push_back(i == 1 ? BLANK : ee.colour);
            step(1'b1, cc, (i == 1), 2'd3, 8'h00, 1'b1, 1'b0);
        end
        bubbles(3);
        check_outs("t5_blank");

        // reset with 3 in flight, then alternating 2bpp/8bpp
        for (int i = 0; i < 3; i++) step(1'b1, VAW'($urandom), 1'b0, 2'd3, 8'h00, 1'b1, 1'b0);
        step(1'b1, VAW'($urandom), 1'b0, 2'd3, 8'h00, 1'b1, 1'b1);
        check_val("t6_reset_valid", 32'(out_valid), 32'd0);
        check_val("t6_reset_pixel", 32'(pixel_out), 32'd0);
        bubbles(4);
        clear_logs();
        for (int i = 0; i < 12; i++) begin
            cc = VAW'($urandom); mm = (i % 2 == 0) ? 2'd1 : 2'd3;
            ee = model(1'b1, cc, 1'b0, mm, PAW'(i * 7));
            want.push_back(ee.colour);
            step(1'b1, cc, 1'b0, mm, PAW'(i * 7), 1'b1, 1'b0);
        end
        bubbles(3);
        check_outs("t6_alt");

        // random traffic: bubbles, stalls, blanks, mode changes, occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), VAW'($urandom), ($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)), PAW'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0));
        end
        bubbles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
